// File: rtl/draw_rect_char_gra2.sv
`default_nettype none
// ============================================================================
// Module      : draw_rect_char_gra2
// Description : Text-overlay stage for the game-2 video path. Scans a 16x16
//               character window (8x16 px glyphs), addresses the char-code and
//               font ROMs, and overlays font pixels onto the RGB stream with a
//               fixed 3-clock latency on every output.
//               Optional build macro: TEXT_BG_EN (opaque text box using
//               BG_COLOR for clear glyph pixels inside the window).
// Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_char_gra2 #(
  parameter int          XPOS     = 32,
  parameter int          YPOS     = 32,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Window bounds in 12 bits so XPOS+128 / YPOS+256 never wrap the compare.
  localparam logic [11:0] X_START = 12'(XPOS);
  localparam logic [11:0] X_END   = 12'(XPOS + 128);
  localparam logic [11:0] Y_START = 12'(YPOS);
  localparam logic [11:0] Y_END   = 12'(YPOS + 256);

  // Only the low bits of the window-relative position are ever needed, and the
  // low bits of a difference depend only on the low bits of its operands.
  logic [6:0] rel_x;
  logic [7:0] rel_y;
  logic       in_area;

  // Stage 1
  logic       in_area_d1;
  logic [2:0] bitsel_d1;
  logic [10:0] hcount_d1, vcount_d1;
  logic       hsync_d1, hblnk_d1, vsync_d1, vblnk_d1;
  logic [11:0] rgb_d1;

  // Stage 2
  logic       in_area_d2;
  logic [2:0] bitsel_d2;
  logic [10:0] hcount_d2, vcount_d2;
  logic       hsync_d2, hblnk_d2, vsync_d2, vblnk_d2;
  logic [11:0] rgb_d2;

  logic        font_bit;
  logic [11:0] clear_rgb;
  logic [11:0] rgb_next;

  // Stage 0: window-relative coordinates and window membership from raw counters
  always_comb begin
    rel_x   = hcount_in[6:0] - 7'(XPOS);
    rel_y   = vcount_in[7:0] - 8'(YPOS);
    in_area = ({1'b0, hcount_in} >= X_START) && ({1'b0, hcount_in} < X_END) &&
              ({1'b0, vcount_in} >= Y_START) && ({1'b0, vcount_in} < Y_END);
  end

  // Stage 1: ROM addressing plus first delay of pixel position and timing
  always_ff @(posedge clk) begin
    if (rst) begin
      char_xy    <= '0;
      char_line  <= '0;
      in_area_d1 <= 1'b0;
      bitsel_d1  <= '0;
      hcount_d1  <= '0;
      hsync_d1   <= 1'b0;
      hblnk_d1   <= 1'b0;
      vcount_d1  <= '0;
      vsync_d1   <= 1'b0;
      vblnk_d1   <= 1'b0;
      rgb_d1     <= '0;
    end else begin
      char_xy    <= in_area ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
      char_line  <= in_area ? rel_y[3:0] : 4'h0;
      in_area_d1 <= in_area;
      bitsel_d1  <= rel_x[2:0];
      hcount_d1  <= hcount_in;
      hsync_d1   <= hsync_in;
      hblnk_d1   <= hblnk_in;
      vcount_d1  <= vcount_in;
      vsync_d1   <= vsync_in;
      vblnk_d1   <= vblnk_in;
      rgb_d1     <= rgb_in;
    end
  end

  // Stage 2: cover the font ROM's registered read
  always_ff @(posedge clk) begin
    if (rst) begin
      in_area_d2 <= 1'b0;
      bitsel_d2  <= '0;
      hcount_d2  <= '0;
      hsync_d2   <= 1'b0;
      hblnk_d2   <= 1'b0;
      vcount_d2  <= '0;
      vsync_d2   <= 1'b0;
      vblnk_d2   <= 1'b0;
      rgb_d2     <= '0;
    end else begin
      in_area_d2 <= in_area_d1;
      bitsel_d2  <= bitsel_d1;
      hcount_d2  <= hcount_d1;
      hsync_d2   <= hsync_d1;
      hblnk_d2   <= hblnk_d1;
      vcount_d2  <= vcount_d1;
      vsync_d2   <= vsync_d1;
      vblnk_d2   <= vblnk_d1;
      rgb_d2     <= rgb_d1;
    end
  end

  // Glyph bit 7 is the leftmost pixel of the character cell.
  assign font_bit = char_pixels[3'd7 - bitsel_d2];

`ifdef TEXT_BG_EN
  assign clear_rgb = in_area_d2 ? BG_COLOR : rgb_d2;
`else
  // Transparent text: BG_COLOR has no effect, the masked term is always zero.
  assign clear_rgb = rgb_d2 | (BG_COLOR & 12'h000);
`endif

  // Pixel priority: blanking, then set glyph pixel, then background/pass-through
  always_comb begin
    rgb_next = clear_rgb;
    if (hblnk_d2 || vblnk_d2) begin
      rgb_next = 12'h000;
    end else if (in_area_d2 && font_bit) begin
      rgb_next = FG_COLOR;
    end
  end

  // Stage 3: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d2;
      hsync_out  <= hsync_d2;
      hblnk_out  <= hblnk_d2;
      vcount_out <= vcount_d2;
      vsync_out  <= vsync_d2;
      vblnk_out  <= vblnk_d2;
      rgb_out    <= rgb_next;
    end
  end

endmodule
`default_nettype wire
